// File: rtl/pipearch_load_if.sv
// rtl/pipearch_load_if.sv - CCI-P c0 channel types and the load stage's c0 bus interface.
// The load stage is the master of c0 requests; the platform side is the slave.
package pipearch_load_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;
endpackage

interface pipearch_load_if;
  logic                             c0TxAlmFull;
  pipearch_load_pkg::t_if_ccip_c0_Rx cp2af_sRx_c0;
  pipearch_load_pkg::t_if_ccip_c0_Tx af2cp_sTx_c0;

  modport master (input c0TxAlmFull, input cp2af_sRx_c0, output af2cp_sTx_c0);
  modport slave  (output c0TxAlmFull, output cp2af_sRx_c0, input af2cp_sTx_c0);
endinterface

// File: rtl/pipearch_load.sv
// rtl/pipearch_load.sv - DRAM-to-BRAM load stage: issues c0 line reads for a window, writes responses to BRAM.
// Responses may return out of order; mdata carries the line index used as the BRAM offset.
module pipearch_load
  import pipearch_load_pkg::*;
#(
  parameter int NUM_REGS        = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           op_start,
  output logic                           op_done,
  input  logic [NUM_REGS-1:0][31:0]      regs,
  input  t_ccip_clAddr                   in_addr,
  input  t_ccip_clAddr                   out_addr,
  pipearch_load_if.master                ccip_c0,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_waddr,
  output logic [511:0]                   mem_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT} send_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DONE} recv_state_t;

  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  send_state_t            send_q;
  recv_state_t            recv_q;
  t_if_ccip_c0_Tx         tx_q;
  t_ccip_clAddr           dram_base_q;
  logic [15:0]            len_q;
  logic [ADDR_WIDTH-1:0]  bram_base_q;
  logic [15:0]            num_issued_q;
  logic [15:0]            num_recv_q;
  logic [7:0]             outstanding_q;
  logic [7:0]             outstanding_d;
  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_waddr_q;
  logic [511:0]           mem_wdata_q;
  logic                   op_done_q;

  logic        start;
  logic        can_issue;
  logic        rsp_accept;
  logic        rsp_dec;
  logic [15:0] start_len;
  logic        unused_ok;

  // Both machines must be idle so a new window never overlaps the tail of the previous one.
  assign start      = op_start && (send_q == S_IDLE) && (recv_q == R_IDLE);
  assign start_len  = regs[1][15:0];
  assign can_issue  = (send_q == S_READ) && !ccip_c0.c0TxAlmFull &&
                      (outstanding_q < MAX_OUT) && (num_issued_q < len_q);
  assign rsp_accept = (recv_q == R_READ) && ccip_c0.cp2af_sRx_c0.rspValid &&
                      (ccip_c0.cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);
  assign rsp_dec    = rsp_accept && (outstanding_q != 8'd0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (start)
      outstanding_d = 8'd0;
    else if (can_issue && !rsp_dec)
      outstanding_d = outstanding_q + 8'd1;
    else if (!can_issue && rsp_dec)
      outstanding_d = outstanding_q - 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      send_q        <= S_IDLE;
      tx_q          <= '0;
      dram_base_q   <= '0;
      len_q         <= '0;
      bram_base_q   <= '0;
      num_issued_q  <= '0;
      outstanding_q <= '0;
    end else begin
      tx_q.valid    <= 1'b0;
      outstanding_q <= outstanding_d;
      case (send_q)
        S_IDLE: begin
          if (start) begin
            dram_base_q  <= (regs[0][31] ? out_addr : in_addr) + t_ccip_clAddr'(regs[0]);
            len_q        <= start_len;
            bram_base_q  <= regs[2][ADDR_WIDTH-1:0];
            num_issued_q <= '0;
            send_q       <= (start_len == 16'd0) ? S_WAIT : S_READ;
          end
        end
        S_READ: begin
          if (can_issue) begin
            tx_q.valid         <= 1'b1;
            tx_q.hdr.vc_sel    <= eVC_VA;
            tx_q.hdr.cl_len    <= eCL_LEN_1;
            tx_q.hdr.req_type  <= eREQ_RDLINE_I;
            tx_q.hdr.address   <= dram_base_q + t_ccip_clAddr'(num_issued_q);
            tx_q.hdr.mdata     <= num_issued_q;
            num_issued_q       <= num_issued_q + 16'd1;
            if (num_issued_q == len_q - 16'd1)
              send_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (recv_q == R_DONE)
            send_q <= S_IDLE;
        end
        default: send_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recv_q      <= R_IDLE;
      num_recv_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      op_done_q   <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      op_done_q <= 1'b0;
      case (recv_q)
        R_IDLE: begin
          if (start) begin
            num_recv_q <= '0;
            recv_q     <= (start_len == 16'd0) ? R_DONE : R_READ;
          end
        end
        R_READ: begin
          if (rsp_accept) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= bram_base_q + ADDR_WIDTH'(ccip_c0.cp2af_sRx_c0.hdr.mdata);
            mem_wdata_q <= ccip_c0.cp2af_sRx_c0.data;
            num_recv_q  <= num_recv_q + 16'd1;
            if (num_recv_q == len_q - 16'd1)
              recv_q <= R_DONE;
          end
        end
        R_DONE: begin
          op_done_q <= 1'b1;
          recv_q    <= R_IDLE;
        end
        default: recv_q <= R_IDLE;
      endcase
    end
  end

  assign ccip_c0.af2cp_sTx_c0 = tx_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign op_done   = op_done_q;

  assign unused_ok = ^{regs, ccip_c0.cp2af_sRx_c0};

endmodule

// File: tb/tb_pipearch_load.sv
// tb/tb_pipearch_load.sv - scoreboard bench for pipearch_load with a wide (64) and a narrow (2) outstanding instance.
module tb_pipearch_load;
  import pipearch_load_pkg::*;

  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 op_start;
  logic [7:0][31:0]     regs;
  t_ccip_clAddr         in_addr;
  t_ccip_clAddr         out_addr;
  logic                 alm;
  t_if_ccip_c0_Rx       rx;
  int                   sel;

  logic                 op_start_w, op_start_n;
  logic                 done_w, done_n, we_w, we_n;
  logic [AW-1:0]        waddr_w, waddr_n;
  logic [511:0]         wdata_w, wdata_n;

  pipearch_load_if ifw ();
  pipearch_load_if ifn ();

  assign ifw.c0TxAlmFull  = alm;
  assign ifn.c0TxAlmFull  = alm;
  assign ifw.cp2af_sRx_c0 = (sel == 0) ? rx : '0;
  assign ifn.cp2af_sRx_c0 = (sel == 1) ? rx : '0;
  assign op_start_w = op_start && (sel == 0);
  assign op_start_n = op_start && (sel == 1);

  pipearch_load #(.NUM_REGS(8), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(64)) dut_w (
    .clk(clk), .reset(reset), .op_start(op_start_w), .op_done(done_w), .regs(regs),
    .in_addr(in_addr), .out_addr(out_addr), .ccip_c0(ifw),
    .mem_we(we_w), .mem_waddr(waddr_w), .mem_wdata(wdata_w));

  pipearch_load #(.NUM_REGS(8), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(2)) dut_n (
    .clk(clk), .reset(reset), .op_start(op_start_n), .op_done(done_n), .regs(regs),
    .in_addr(in_addr), .out_addr(out_addr), .ccip_c0(ifn),
    .mem_we(we_n), .mem_waddr(waddr_n), .mem_wdata(wdata_n));

  t_if_ccip_c0_Tx tx;
  logic           m_we, m_done;
  logic [AW-1:0]  m_waddr;
  logic [511:0]   m_wdata;
  assign tx      = (sel == 1) ? ifn.af2cp_sTx_c0 : ifw.af2cp_sTx_c0;
  assign m_we    = (sel == 1) ? we_n : we_w;
  assign m_done  = (sel == 1) ? done_n : done_w;
  assign m_waddr = (sel == 1) ? waddr_n : waddr_w;
  assign m_wdata = (sel == 1) ? wdata_n : wdata_w;

  always #5 clk = ~clk;

  typedef struct packed {t_ccip_clAddr addr; logic [15:0] mdata;} req_t;
  typedef struct packed {logic [AW-1:0] a; logic [511:0] d;} wr_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  int   exp_done[$];

  int            n_tests = 0, n_fail = 0;
  int            cyc = 0;
  int            req_seen = 0, done_seen = 0, inflight = 0;
  int            lim = 64;
  int            op_id = 0;
  logic [AW-1:0] cur_b;
  logic          alm_prev = 1'b0;
  req_t          r;
  wr_t           w;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [511:0] pat(logic [15:0] m);
    logic [31:0] wd;
    wd = {8'hA5, 8'(op_id), m};
    return {16{wd}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the selected DUT presents a request, a write or op_done.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx.valid) begin
        req_seen++;
        inflight++;
        chk("req_during_almfull", alm_prev, 1'b0);
        chk("req_inflight_limit", inflight <= lim, 1'b1);
        if (exp_req.size() == 0) chk("req_unexpected", 1'b1, 1'b0);
        else begin
          r = exp_req.pop_front();
          chk("req_addr", tx.hdr.address, r.addr);
          chk("req_mdata", tx.hdr.mdata, r.mdata);
          chk("req_hdr", {tx.hdr.vc_sel, tx.hdr.cl_len, tx.hdr.req_type},
              {eVC_VA, eCL_LEN_1, eREQ_RDLINE_I});
        end
      end
      if (m_we) begin
        if (exp_wr.size() == 0) chk("we_unexpected", 1'b1, 1'b0);
        else begin
          w = exp_wr.pop_front();
          chk("waddr", m_waddr, w.a);
          chk("wdata", m_wdata, w.d);
        end
      end
      if (m_done) begin
        done_seen++;
        if (exp_done.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
        else begin
          chk("done_cycle", cyc, exp_done.pop_front());
          chk("done_after_writes", exp_wr.size(), 0);
        end
      end
    end
    alm_prev = alm;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(int s, logic [31:0] r0, logic [15:0] len, logic [AW-1:0] b);
    t_ccip_clAddr base;
    sel     = s;
    lim     = (s == 1) ? 2 : 64;
    op_id++;
    cur_b   = b;
    regs[0] = r0;
    regs[1] = {16'hDEAD, len};
    regs[2] = 32'hFFFF_FC00 | 32'(b);
    base = (r0[31] ? out_addr : in_addr) + t_ccip_clAddr'(r0);
    for (int i = 0; i < int'(len); i++) exp_req.push_back({base + t_ccip_clAddr'(i), 16'(i)});
    if (len == 16'd0) exp_done.push_back(cyc + 2);
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
  endtask

  task automatic rsp(logic [15:0] m, bit last);
    rx = '0;
    rx.rspValid      = 1'b1;
    rx.hdr.resp_type = eRSP_RDLINE;
    rx.hdr.mdata     = m;
    rx.data          = pat(m);
    exp_wr.push_back({cur_b + AW'(m), pat(m)});
    inflight--;
    if (last) exp_done.push_back(cyc + 2);
    tick();
    rx = '0;
  endtask

  task automatic raw_rsp(logic [15:0] m, logic rv, t_ccip_c0_rsp t, logic mmio);
    rx = '0;
    rx.rspValid      = rv;
    rx.mmioWrValid   = mmio;
    rx.hdr.resp_type = t;
    rx.hdr.mdata     = m;
    rx.data          = {16{32'hBAD0_0000 | 32'(m)}};
    tick();
    rx = '0;
  endtask

  task automatic wait_reqs(int n);
    for (int i = 0; i < 200 && req_seen < n; i++) tick();
    chk("wait_reqs_timeout", req_seen >= n, 1'b1);
  endtask

  task automatic wait_done(int n);
    for (int i = 0; i < 200 && done_seen < n; i++) tick();
    chk("wait_done_timeout", done_seen >= n, 1'b1);
  endtask

  initial begin
    int b;
    reset    = 1'b1;
    op_start = 1'b0;
    regs     = '0;
    in_addr  = 42'h1000;
    out_addr = 42'h8000;
    alm      = 1'b0;
    rx       = '0;
    sel      = 0;
    repeat (3) tick();
    chk("rst_valid_w", ifw.af2cp_sTx_c0.valid, 1'b0);
    chk("rst_we_w", we_w, 1'b0);
    chk("rst_done_w", done_w, 1'b0);
    chk("rst_valid_n", ifn.af2cp_sTx_c0.valid, 1'b0);
    chk("rst_we_n", we_n, 1'b0);
    reset = 1'b0;
    tick();

    // L=4 in order from in_addr+0x10
    b = req_seen;
    start_op(0, 32'h10, 16'd4, 10'h000);
    for (int i = 0; i < 4; i++) begin
      wait_reqs(b + i + 1);
      rsp(16'(i), i == 3);
    end
    wait_done(1);
    chk("t1_req_count", req_seen - b, 4);

    // L=0: done at T+2 and nothing else
    b = req_seen;
    start_op(0, 32'h20, 16'd0, 10'h005);
    wait_done(2);
    repeat (3) tick();
    chk("t2_no_reqs", req_seen - b, 0);

    // L=8 with BRAM base 0x3FE, reverse-order responses wrap the address
    b = req_seen;
    start_op(0, 32'h40, 16'd8, 10'h3FE);
    wait_reqs(b + 8);
    for (int i = 7; i >= 0; i--) rsp(16'(i), i == 0);
    wait_done(3);

    // Narrow instance: 2 in flight, AlmFull stalls issue
    b = req_seen;
    start_op(1, 32'h100, 16'd6, 10'h010);
    wait_reqs(b + 2);
    repeat (4) tick();
    chk("t4_capped_at_2", req_seen - b, 2);
    rsp(16'd0, 1'b0);
    wait_reqs(b + 3);
    alm = 1'b1;
    rsp(16'd1, 1'b0);
    repeat (4) tick();
    chk("t4_almfull_hold", req_seen - b, 3);
    alm = 1'b0;
    for (int i = 2; i < 6; i++) begin
      wait_reqs(b + i + 1);
      rsp(16'(i), i == 5);
    end
    wait_done(4);

    // Non-RDLINE c0 traffic mixed into READ is ignored
    b = req_seen;
    start_op(0, 32'h80, 16'd3, 10'h020);
    wait_reqs(b + 3);
    rsp(16'd0, 1'b0);
    raw_rsp(16'd1, 1'b0, eRSP_RDLINE, 1'b1);
    raw_rsp(16'd2, 1'b1, eRSP_UMSG, 1'b0);
    rsp(16'd1, 1'b0);
    rsp(16'd2, 1'b1);
    wait_done(5);

    // Reset after 3 of 6 responses, while the third write is on the BRAM port
    b = req_seen;
    start_op(0, 32'h180, 16'd6, 10'h100);
    wait_reqs(b + 6);
    rsp(16'd0, 1'b0);
    rsp(16'd1, 1'b0);
    rsp(16'd2, 1'b0);
    #5;
    chk("t6_we_before_reset", we_w, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_rst_we", we_w, 1'b0);
    chk("t6_rst_valid", ifw.af2cp_sTx_c0.valid, 1'b0);
    chk("t6_rst_done", done_w, 1'b0);
    inflight = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    raw_rsp(16'd3, 1'b1, eRSP_RDLINE, 1'b0);
    raw_rsp(16'd4, 1'b1, eRSP_RDLINE, 1'b0);
    raw_rsp(16'd5, 1'b1, eRSP_RDLINE, 1'b0);
    repeat (3) tick();
    b = req_seen;
    start_op(0, 32'h200, 16'd2, 10'h3F0);
    wait_reqs(b + 2);
    rsp(16'd0, 1'b0);
    rsp(16'd1, 1'b1);
    wait_done(6);

    repeat (5) tick();
    chk("end_req_queue", exp_req.size(), 0);
    chk("end_wr_queue", exp_wr.size(), 0);
    chk("end_done_queue", exp_done.size(), 0);
    chk("end_done_count", done_seen, 6);
    chk("end_req_total", req_seen, 29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
